// File: rtl/sr_seq_pkg.sv
// Shared types for the SR command sequencer: command codes, FSM states and
// the mapping from a command code to the {x,y} drive codes of the downstream flop.
package sr_seq_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_SET_Y = 2'b01,
    CMD_SET_X = 2'b10,
    CMD_HOLD  = 2'b11
  } cmd_code_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
  } xy_t;

  // 11/11 leaves the downstream flop unchanged; 00/00 clears it.
  localparam xy_t XY_IDLE  = '{x: 2'b11, y: 2'b11};
  localparam xy_t XY_RESET = '{x: 2'b00, y: 2'b00};

  function automatic xy_t code_to_xy(input cmd_code_e code);
    code_to_xy = XY_IDLE;
    unique case (code)
      CMD_CLEAR: code_to_xy = '{x: 2'b00, y: 2'b00};
      CMD_SET_Y: code_to_xy = '{x: 2'b00, y: 2'b01};
      CMD_SET_X: code_to_xy = '{x: 2'b01, y: 2'b00};
      CMD_HOLD:  code_to_xy = '{x: 2'b11, y: 2'b11};
    endcase
  endfunction

endpackage

// File: rtl/sr_cmd_fifo.sv
// Synchronous command FIFO; registered storage so a pushed entry is visible
// at the head no earlier than the edge after the push.
module sr_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // Fullness ignores a same-edge pop, so a push offered while full is dropped.
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Queues {code, dwell} commands and drives each code onto the downstream
// sr_ff x/y inputs for dwell+1 cycles, back-to-back when commands are queued.
module sr_cmd_sequencer
  import sr_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic [1:0]             cmd_code,
  input  logic [DW-1:0]          cmd_dwell,
  output logic                   cmd_ready,
  output logic [1:0]             x,
  output logic [1:0]             y,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned FW = 2 + DW;

  seq_state_e    state;
  seq_state_e    state_n;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_n;
  xy_t           xy;
  xy_t           xy_n;

  logic          pop;
  logic          full;
  logic          empty;
  logic [FW-1:0] head;
  cmd_code_e     head_code;
  logic [DW-1:0] head_dwell;

  sr_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   ({cmd_code, cmd_dwell}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign head_code  = cmd_code_e'(head[FW-1:DW]);
  assign head_dwell = head[DW-1:0];

  assign cmd_ready = !full;
  assign busy      = (state == ST_DRIVE);
  assign done      = (state == ST_DRIVE) && (cnt == '0);
  assign x         = xy.x;
  assign y         = xy.y;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      xy    <= XY_RESET;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      xy    <= xy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    xy_n    = xy;
    pop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          xy_n    = code_to_xy(head_code);
          cnt_n   = head_dwell;
          state_n = ST_DRIVE;
        end else begin
          xy_n = XY_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt != '0) begin
          cnt_n = cnt - DW'(1);
        end else if (!empty) begin
          // Reload straight from DRIVE so consecutive commands leave no idle gap.
          pop   = 1'b1;
          xy_n  = code_to_xy(head_code);
          cnt_n = head_dwell;
        end else begin
          xy_n    = XY_IDLE;
          state_n = ST_IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Scoreboard bench for sr_cmd_sequencer: accepted offers queue their expected
// per-cycle drive codes; a negedge monitor compares whenever the block is busy.
module tb_sr_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 4;

  localparam logic [1:0] C_CLEAR = 2'b00;
  localparam logic [1:0] C_SET_Y = 2'b01;
  localparam logic [1:0] C_SET_X = 2'b10;
  localparam logic [1:0] C_HOLD  = 2'b11;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic       done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_code = 2'b00;
  logic [DW-1:0] cmd_dwell = '0;
  logic          cmd_ready;
  logic [1:0]    x;
  logic [1:0]    y;
  logic          busy;
  logic          done;
  logic [$clog2(DEPTH):0] level;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  logic last_edge_rst = 1'b1;

  sr_cmd_sequencer #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_dwell (cmd_dwell),
    .cmd_ready (cmd_ready),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .level     (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) last_edge_rst <= rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  function automatic logic [3:0] exp_xy(input logic [1:0] c);
    case (c)
      C_CLEAR: return 4'b0000;
      C_SET_Y: return 4'b0001;
      C_SET_X: return 4'b0100;
      default: return 4'b1111;
    endcase
  endfunction

  // Monitor: reset values, per-cycle drive codes while busy, 11/11 when idle.
  always @(negedge clk) begin
    exp_t e;
    if (last_edge_rst) begin
      chk("rst_xy", {x, y}, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_level", level, 0);
      chk("rst_ready", cmd_ready, 1'b1);
    end else if (busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_drive: got x/y %b/%b done %b expected no drive at %0t", x, y, done, $time);
      end else begin
        e = exp_q.pop_front();
        chk("drive_xy", {x, y}, {e.x, e.y});
        chk("drive_done", done, e.done);
      end
    end else begin
      chk("idle_xy", {x, y}, 4'b1111);
      chk("idle_done", done, 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command across the next edge; exp_acc is the hand-derived acceptance.
  task automatic offer(input logic [1:0] c, input int unsigned d, input bit exp_acc);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_code  = c;
    cmd_dwell = DW'(d);
    chk("ready_at_offer", cmd_ready, exp_acc);
    if (exp_acc) begin
      for (int unsigned i = 0; i <= d; i++) begin
        {e.x, e.y} = exp_xy(c);
        e.done     = (i == d);
        exp_q.push_back(e);
      end
    end
    step();
  endtask

  task automatic wait_idle(input int unsigned max_cycles);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < max_cycles; i++) begin
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      $display("FAIL drain_timeout: got busy=%b pending=%0d expected idle and empty", busy, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int first;
    int last;
    int nbusy;

    // Reset then idle.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) step();
    chk("idle_level", level, 0);
    chk("idle_ready", cmd_ready, 1'b1);

    // Single SET_X dwell 2: drive starts the edge after acceptance.
    offer(C_SET_X, 2, 1'b1);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("latency_not_yet", busy, 1'b0);
    @(negedge clk);
    chk("latency_busy", busy, 1'b1);
    chk("latency_x", x, 2'b01);
    step();
    wait_idle(20);

    // Three back-to-back dwell-0 commands: one contiguous 3-cycle busy run.
    first = -1;
    last  = -1;
    nbusy = 0;
    fork
      begin
        offer(C_CLEAR, 0, 1'b1);
        offer(C_SET_Y, 0, 1'b1);
        offer(C_SET_X, 0, 1'b1);
        cmd_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (busy) begin
            if (first < 0) first = i;
            last = i;
            nbusy++;
          end
        end
      end
    join
    chk("b2b_busy_cycles", nbusy, 3);
    chk("b2b_contiguous", last - first + 1, 3);
    step();
    wait_idle(20);

    // Fill while driving a long command: four accepted, two dropped.
    offer(C_SET_Y, 15, 1'b1);
    cmd_valid = 1'b0;
    step();
    offer(C_CLEAR, 15, 1'b1);
    offer(C_SET_X, 15, 1'b1);
    offer(C_HOLD,  15, 1'b1);
    offer(C_SET_Y, 15, 1'b1);
    chk("full_level", level, 4);
    offer(C_SET_X, 15, 1'b0);
    offer(C_CLEAR, 15, 1'b0);
    cmd_valid = 1'b0;
    chk("full_level_after_drops", level, 4);
    wait_idle(120);

    // Reset during DRIVE with three queued: everything discarded.
    offer(C_SET_X, 10, 1'b1);
    cmd_valid = 1'b0;
    step();
    offer(C_SET_Y, 0, 1'b1);
    offer(C_CLEAR, 0, 1'b1);
    offer(C_HOLD,  0, 1'b1);
    cmd_valid = 1'b0;
    chk("pre_rst_level", level, 3);
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1 rst = 1'b0;
    repeat (3) step();
    chk("post_rst_level", level, 0);
    chk("post_rst_busy", busy, 1'b0);
    wait_idle(5);

    // Full FIFO with pop and offer on the same edge: offer dropped, next one taken.
    offer(C_SET_X, 7, 1'b1);
    cmd_valid = 1'b0;
    step();
    offer(C_CLEAR, 0, 1'b1);
    offer(C_SET_Y, 0, 1'b1);
    offer(C_HOLD,  0, 1'b1);
    offer(C_SET_X, 0, 1'b1);
    offer(C_SET_Y, 1, 1'b0);
    offer(C_SET_Y, 1, 1'b0);
    offer(C_SET_Y, 1, 1'b0);
    chk("pop_edge_level_before", level, 4);
    offer(C_SET_Y, 1, 1'b0);
    chk("pop_edge_level_after", level, 3);
    chk("pop_edge_ready_after", cmd_ready, 1'b1);
    offer(C_SET_Y, 1, 1'b1);
    cmd_valid = 1'b0;
    wait_idle(40);

    repeat (3) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
